// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP-RISC multi-cycle control unit.
// Covers the FSM states, instruction classes, opcodes and datapath select codes.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_BL      = 4'd5,
    CLS_BR      = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_cls_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_SIGN   = 2'd1,
    COND_ZERO   = 2'd2,
    COND_NZERO  = 2'd3
  } br_cond_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ALUI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b010000;
  localparam logic [5:0] OP_SW    = 6'b010001;
  localparam logic [5:0] OP_B     = 6'b110000;
  localparam logic [5:0] OP_BL    = 6'b110001;
  localparam logic [5:0] OP_BR    = 6'b110010;
  localparam logic [5:0] OP_BLTZ  = 6'b110101;
  localparam logic [5:0] OP_BZ    = 6'b110110;
  localparam logic [5:0] OP_BNZ   = 6'b110111;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Loads and stores compute their address with the add function.
  localparam logic [4:0] FUNC_ADD = 5'd1;
  localparam logic [4:0] FUNC_SLL = 5'd8;
  localparam logic [4:0] FUNC_SRL = 5'd9;
  localparam logic [4:0] FUNC_SRA = 5'd10;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_REG    = 2'd2;

  localparam logic [1:0] W_SEL_RD   = 2'd0;
  localparam logic [1:0] W_SEL_RT   = 2'd1;
  localparam logic [1:0] W_SEL_LINK = 2'd2;

  localparam logic [1:0] B_SRC_REG   = 2'd0;
  localparam logic [1:0] B_SRC_IMM   = 2'd1;
  localparam logic [1:0] B_SRC_SHAMT = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  function automatic logic is_shift(input logic [4:0] func);
    return (func == FUNC_SLL) || (func == FUNC_SRL) || (func == FUNC_SRA);
  endfunction

endpackage

// File: rtl/multicycle_controller_decoder.sv
// Combinational instruction decoder: classifies the IR and produces the
// per-instruction ALU, operand-B and write-back selects.
module instr_decoder
  import kgp_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ALU_C_W = 5
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [3:0]         cls_o,
  output logic [1:0]         cond_o,
  output logic               illegal_o,
  output logic [ALU_C_W-1:0] alu_c_o,
  output logic [1:0]         b_src_o,
  output logic [1:0]         w_select_o
);

  logic [5:0] opcode_s;
  logic [4:0] func_s;
  logic       unused_bits_s;

  assign opcode_s      = instr_i[INSTR_W-1 -: 6];
  assign func_s        = instr_i[4:0];
  assign unused_bits_s = ^instr_i[INSTR_W-7:5];

  always_comb begin
    cls_o      = CLS_ILLEGAL;
    cond_o     = COND_ALWAYS;
    illegal_o  = 1'b0;
    alu_c_o    = '0;
    b_src_o    = B_SRC_REG;
    w_select_o = W_SEL_RD;
    case (opcode_s)
      OP_RTYPE: begin
        cls_o   = CLS_ALU_R;
        alu_c_o = ALU_C_W'(func_s);
        if (is_shift(func_s)) begin
          b_src_o = B_SRC_SHAMT;
        end else begin
          b_src_o = B_SRC_REG;
        end
      end
      OP_ALUI: begin
        cls_o      = CLS_ALU_I;
        alu_c_o    = ALU_C_W'(func_s);
        b_src_o    = B_SRC_IMM;
        w_select_o = W_SEL_RT;
      end
      OP_LW: begin
        cls_o      = CLS_LOAD;
        alu_c_o    = ALU_C_W'(FUNC_ADD);
        b_src_o    = B_SRC_IMM;
        w_select_o = W_SEL_RT;
      end
      OP_SW: begin
        cls_o   = CLS_STORE;
        alu_c_o = ALU_C_W'(FUNC_ADD);
        b_src_o = B_SRC_IMM;
      end
      OP_B:    cls_o = CLS_BRANCH;
      OP_BL: begin
        cls_o      = CLS_BL;
        w_select_o = W_SEL_LINK;
      end
      OP_BR:   cls_o = CLS_BR;
      OP_BLTZ: begin
        cls_o  = CLS_BRANCH;
        cond_o = COND_SIGN;
      end
      OP_BZ: begin
        cls_o  = CLS_BRANCH;
        cond_o = COND_ZERO;
      end
      OP_BNZ: begin
        cls_o  = CLS_BRANCH;
        cond_o = COND_NZERO;
      end
      OP_HALT: cls_o = CLS_HALT;
      default: begin
        cls_o     = CLS_ILLEGAL;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle KGP-RISC control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing,
// memory handshake with a saturating wait counter, and branch resolution.
module multicycle_controller
  import kgp_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ALU_C_W = 5,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               zero_i,
  input  logic               sign_i,
  input  logic               imem_ready_i,
  input  logic               dmem_ready_i,
  output logic               imem_req_o,
  output logic               dmem_req_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               reg_write_o,
  output logic               mem_to_reg_o,
  output logic               flag_write_o,
  output logic [1:0]         w_select_o,
  output logic [ALU_C_W-1:0] alu_c_o,
  output logic [1:0]         b_src_o,
  output logic [2:0]         state_o,
  output logic               halted_o,
  output logic               bus_error_o,
  output logic               illegal_instr_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             bus_err_q, bus_err_d;
  logic             active_q, active_d;
  logic             timeout_s, taken_s;

  logic [3:0]         dec_cls_s;
  logic [1:0]         dec_cond_s;
  logic               dec_illegal_s;
  logic [ALU_C_W-1:0] dec_alu_c_s;
  logic [1:0]         dec_b_src_s;
  logic [1:0]         dec_w_select_s;

  instr_decoder #(.INSTR_W(INSTR_W), .ALU_C_W(ALU_C_W)) u_decoder (
    .instr_i    (instr_i),
    .cls_o      (dec_cls_s),
    .cond_o     (dec_cond_s),
    .illegal_o  (dec_illegal_s),
    .alu_c_o    (dec_alu_c_s),
    .b_src_o    (dec_b_src_s),
    .w_select_o (dec_w_select_s)
  );

  // Ready always beats timeout because the ready test comes first below.
  assign cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 1'b1);
  assign timeout_s   = (TIMEOUT > 0) && (cnt_q >= CNT_LAST);
  assign state_o     = state_q;
  assign bus_error_o = bus_err_q;

  // Branch condition from the flag register.
  always_comb begin
    case (dec_cond_s)
      COND_ALWAYS: taken_s = 1'b1;
      COND_SIGN:   taken_s = sign_i;
      COND_ZERO:   taken_s = zero_i;
      COND_NZERO:  taken_s = !zero_i;
      default:     taken_s = 1'b0;
    endcase
  end

  // Next-state, wait-counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    bus_err_d = bus_err_q;
    active_d = 1'b1;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    mem_read_o = 1'b0;
    mem_write_o = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    pc_src_o = PC_SRC_SEQ;
    reg_write_o = 1'b0;
    mem_to_reg_o = 1'b0;
    flag_write_o = 1'b0;
    w_select_o = W_SEL_RD;
    alu_c_o = '0;
    b_src_o = B_SRC_REG;
    halted_o = 1'b0;
    illegal_instr_o = 1'b0;
    // active_q holds outputs quiet for the first cycle after reset release.
    if (active_q) begin
      case (state_q)
        ST_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            pc_src_o   = PC_SRC_SEQ;
            state_d    = ST_DECODE;
          end else if (timeout_s) begin
            state_d   = ST_HALT;
            bus_err_d = 1'b1;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_DECODE: begin
          if (dec_illegal_s) begin
            illegal_instr_o = 1'b1;
            state_d = ST_FETCH;
          end else if (dec_cls_s == CLS_HALT) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_c_o = dec_alu_c_s;
          b_src_o = dec_b_src_s;
          case (dec_cls_s)
            CLS_ALU_R: begin
              flag_write_o = 1'b1;
              state_d = ST_WB;
            end
            CLS_ALU_I:            state_d = ST_WB;
            CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
            CLS_BRANCH, CLS_BL, CLS_BR: begin
              if (taken_s) begin
                pc_write_o = 1'b1;
                pc_src_o = (dec_cls_s == CLS_BR) ? PC_SRC_REG : PC_SRC_BRANCH;
              end else begin
                pc_write_o = 1'b0;
              end
              state_d = (dec_cls_s == CLS_BL) ? ST_WB : ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          dmem_req_o  = 1'b1;
          mem_read_o  = (dec_cls_s == CLS_LOAD);
          mem_write_o = (dec_cls_s == CLS_STORE);
          if (dmem_ready_i) begin
            state_d = (dec_cls_s == CLS_LOAD) ? ST_WB : ST_FETCH;
          end else if (timeout_s) begin
            state_d   = ST_HALT;
            bus_err_d = 1'b1;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        ST_WB: begin
          reg_write_o  = 1'b1;
          w_select_o   = dec_w_select_s;
          mem_to_reg_o = (dec_cls_s == CLS_LOAD);
          state_d      = ST_FETCH;
        end
        ST_HALT: begin
          halted_o = 1'b1;
          state_d  = ST_HALT;
        end
        default: state_d = ST_HALT;
      endcase
    end else begin
      state_d = ST_FETCH;
    end
  end

  // State, counter and sticky-flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller (TIMEOUT=4).
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, mem_to_reg, flag_write;
    logic [1:0] w_sel;
    logic [4:0] alu_c;
    logic [1:0] b_src;
    logic       halted, bus_err, illegal;
  } outs_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        z, s, ir, dr;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] I_LW   = 32'h4001_0000;
  localparam logic [31:0] I_ADD  = 32'h0040_0001;
  localparam logic [31:0] I_BZ   = 32'hD860_0038;
  localparam logic [31:0] I_ILL  = 32'h8000_0000;
  localparam logic [31:0] I_ADDI = 32'h0400_0005;
  localparam logic [31:0] I_BL   = 32'hC400_0000;
  localparam logic [31:0] I_BR   = 32'hC800_0000;
  localparam logic [31:0] I_BLTZ = 32'hD400_0000;
  localparam logic [31:0] I_BNZ  = 32'hDC00_0000;
  localparam logic [31:0] I_SW   = 32'h4400_0000;
  localparam logic [31:0] I_B    = 32'hC000_0000;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0, sign = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write;
  logic [1:0]  pc_src, w_select, b_src;
  logic        reg_write, mem_to_reg, flag_write, halted, bus_error, illegal_instr;
  logic [4:0]  alu_c;
  logic [2:0]  state;
  outs_t       act;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        vec[$];

  always #5 clk = ~clk;

  multicycle_controller #(.INSTR_W(32), .ALU_C_W(5), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .zero_i(zero), .sign_i(sign),
    .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .pc_src_o(pc_src), .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg),
    .flag_write_o(flag_write), .w_select_o(w_select), .alu_c_o(alu_c),
    .b_src_o(b_src), .state_o(state), .halted_o(halted), .bus_error_o(bus_error),
    .illegal_instr_o(illegal_instr)
  );

  assign act = {state, imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write,
                pc_src, reg_write, mem_to_reg, flag_write, w_select, alu_c, b_src,
                halted, bus_error, illegal_instr};

  function automatic outs_t o_zero();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t o_fw();
    outs_t o = '0;
    o.imem_req = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_fd();
    outs_t o = '0;
    o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'd0;
    return o;
  endfunction
  function automatic outs_t o_dec(input logic ill);
    outs_t o = '0;
    o.st = 3'd1; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t o_ex(input logic [4:0] alu, input logic [1:0] bs,
                                 input logic fw, input logic pcw, input logic [1:0] pcs);
    outs_t o = '0;
    o.st = 3'd2; o.alu_c = alu; o.b_src = bs; o.flag_write = fw;
    o.pc_write = pcw; o.pc_src = pcs;
    return o;
  endfunction
  function automatic outs_t o_mem(input logic rd, input logic wr);
    outs_t o = '0;
    o.st = 3'd3; o.dmem_req = 1'b1; o.mem_read = rd; o.mem_write = wr;
    return o;
  endfunction
  function automatic outs_t o_wb(input logic [1:0] ws, input logic m2r);
    outs_t o = '0;
    o.st = 3'd4; o.reg_write = 1'b1; o.w_sel = ws; o.mem_to_reg = m2r;
    return o;
  endfunction
  function automatic outs_t o_halt(input logic be);
    outs_t o = '0;
    o.st = 3'd5; o.halted = 1'b1; o.bus_err = be;
    return o;
  endfunction

  task automatic check(input string nm, input outs_t e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h (state %0d) want %h (state %0d)", nm, act, act.st, e, e.st);
    end
  endtask

  task automatic add(input string nm, input logic [31:0] ins, input logic z, input logic s,
                     input logic ir, input logic dr, input outs_t e);
    vec_t v;
    v.nm = nm; v.ins = ins; v.z = z; v.s = s; v.ir = ir; v.dr = dr; v.exp = e;
    vec.push_back(v);
  endtask

  // Drive one cycle's inputs just after the edge, check mid-cycle, advance.
  task automatic step(input string nm, input logic [31:0] ins, input logic z, input logic s,
                      input logic ir, input logic dr, input outs_t e);
    instr = ins; zero = z; sign = s; imem_ready = ir; dmem_ready = dr;
    #3;
    check(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #2;
    check({nm, "_async"}, o_zero());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    check({nm, "_idle"}, o_zero());
    @(posedge clk);
    #1;
  endtask

  initial begin
    add("lw_f0", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_fw());
    add("lw_f1", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_fw());
    add("lw_f2", I_LW, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("lw_dec", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("lw_ex", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd1, 2'd1, 1'b0, 1'b0, 2'd0));
    add("lw_mem", I_LW, 1'b0, 1'b0, 1'b0, 1'b1, o_mem(1'b1, 1'b0));
    add("lw_wb", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_wb(2'd1, 1'b1));
    add("add_f", I_ADD, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("add_dec", I_ADD, 1'b0, 1'b0, 1'b1, 1'b1, o_dec(1'b0));
    add("add_ex", I_ADD, 1'b0, 1'b0, 1'b1, 1'b1, o_ex(5'd1, 2'd0, 1'b1, 1'b0, 2'd0));
    add("add_wb", I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, o_wb(2'd0, 1'b0));
    add("bzt_f", I_BZ, 1'b1, 1'b0, 1'b1, 1'b0, o_fd());
    add("bzt_dec", I_BZ, 1'b1, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("bzt_ex", I_BZ, 1'b1, 1'b0, 1'b0, 1'b0, o_ex(5'd0, 2'd0, 1'b0, 1'b1, 2'd1));
    add("bzn_f", I_BZ, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("bzn_dec", I_BZ, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("bzn_ex", I_BZ, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd0, 2'd0, 1'b0, 1'b0, 2'd0));
    add("ill_f", I_ILL, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("ill_dec", I_ILL, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b1));
    add("addi_f0", I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, o_fw());
    add("addi_f1", I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, o_fw());
    add("addi_f2", I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, o_fw());
    add("addi_f3_ready_wins", I_ADDI, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("addi_dec", I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("addi_ex", I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd5, 2'd1, 1'b0, 1'b0, 2'd0));
    add("addi_wb", I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, o_wb(2'd1, 1'b0));
    add("bl_f", I_BL, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("bl_dec", I_BL, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("bl_ex", I_BL, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd0, 2'd0, 1'b0, 1'b1, 2'd1));
    add("bl_wb", I_BL, 1'b0, 1'b0, 1'b0, 1'b0, o_wb(2'd2, 1'b0));
    add("br_f", I_BR, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("br_dec", I_BR, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("br_ex", I_BR, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd0, 2'd0, 1'b0, 1'b1, 2'd2));
    add("bltz_f", I_BLTZ, 1'b0, 1'b1, 1'b1, 1'b0, o_fd());
    add("bltz_dec", I_BLTZ, 1'b0, 1'b1, 1'b0, 1'b0, o_dec(1'b0));
    add("bltz_ex", I_BLTZ, 1'b0, 1'b1, 1'b0, 1'b0, o_ex(5'd0, 2'd0, 1'b0, 1'b1, 2'd1));
    add("bnz_f", I_BNZ, 1'b1, 1'b0, 1'b1, 1'b0, o_fd());
    add("bnz_dec", I_BNZ, 1'b1, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("bnz_ex_nt", I_BNZ, 1'b1, 1'b0, 1'b0, 1'b0, o_ex(5'd0, 2'd0, 1'b0, 1'b0, 2'd0));
    add("sw_f", I_SW, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("sw_dec", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("sw_ex", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd1, 2'd1, 1'b0, 1'b0, 2'd0));
    add("sw_m0", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b0, 1'b1));
    add("sw_m1", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b0, 1'b1));
    add("sw_m2", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b0, 1'b1));
    add("sw_m3_ready_wins", I_SW, 1'b0, 1'b0, 1'b0, 1'b1, o_mem(1'b0, 1'b1));
    add("b_f", I_B, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    add("b_dec", I_B, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    add("b_ex", I_B, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd0, 2'd0, 1'b0, 1'b1, 2'd1));

    #1;
    do_reset("rst0");
    foreach (vec[i]) step(vec[i].nm, vec[i].ins, vec[i].z, vec[i].s, vec[i].ir, vec[i].dr, vec[i].exp);

    // Store whose data memory never answers: request held 4 cycles, then sticky HALT.
    step("swto_f", I_SW, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    step("swto_dec", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    step("swto_ex", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd1, 2'd1, 1'b0, 1'b0, 2'd0));
    for (int k = 0; k < 4; k++) step("swto_wait", I_SW, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b0, 1'b1));
    step("swto_halt0", I_SW, 1'b0, 1'b0, 1'b1, 1'b1, o_halt(1'b1));
    step("swto_halt1", I_SW, 1'b0, 1'b0, 1'b1, 1'b1, o_halt(1'b1));
    do_reset("rst_after_to");

    // Reset asserted while a load waits in MEM.
    step("lwr_f", I_LW, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    step("lwr_dec", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    step("lwr_ex", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_ex(5'd1, 2'd1, 1'b0, 1'b0, 2'd0));
    step("lwr_wait", I_LW, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b1, 1'b0));
    do_reset("rst_mid_mem");

    // Halt instruction: halted without bus error.
    step("halt_f", I_HALT, 1'b0, 1'b0, 1'b1, 1'b0, o_fd());
    step("halt_dec", I_HALT, 1'b0, 1'b0, 1'b0, 1'b0, o_dec(1'b0));
    step("halt_s0", I_HALT, 1'b0, 1'b0, 1'b1, 1'b1, o_halt(1'b0));
    step("halt_s1", I_ADD, 1'b0, 1'b0, 1'b1, 1'b1, o_halt(1'b0));
    do_reset("rst_after_halt");

    // Instruction fetch timeout.
    for (int k = 0; k < 4; k++) step("fto_wait", I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, o_fw());
    step("fto_halt", I_ADD, 1'b0, 1'b0, 1'b1, 1'b0, o_halt(1'b1));
    do_reset("rst_after_fto");
    step("post_fetch", I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, o_fw());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
